// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the ALU control decoder.
package mul_div_unit_pkg;

    localparam int MDU_W = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate of a {hi,lo} pair. With wide=1 the
// pair is one 64-bit value negated by neg_lo; otherwise each half is
// negated on its own flag (operand magnitudes, quotient/remainder).
module mdu_sign_fix
    import mul_div_unit_pkg::*;
(
    input  logic [2*MDU_W-1:0] din,
    input  logic               wide,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*MDU_W-1:0] dout
);

    // Pick between full-width negate and per-half negate
    always_comb begin
        dout = din;
        if (wide) begin
            if (neg_lo) dout = (~din) + {{(2*MDU_W-1){1'b0}}, 1'b1};
        end else begin
            if (neg_hi) dout[2*MDU_W-1:MDU_W] = (~din[2*MDU_W-1:MDU_W]) + {{(MDU_W-1){1'b0}}, 1'b1};
            if (neg_lo) dout[MDU_W-1:0]       = (~din[MDU_W-1:0]) + {{(MDU_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are computed at issue, ITER shift-add / restoring-divide steps
// run one per cycle, and signs are restored in FIX while writing HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [MDU_W-1:0] din1,
    input  logic [MDU_W-1:0] din2,
    input  logic             flush,
    output logic             busy,
    output logic [MDU_W-1:0] hi,
    output logic [MDU_W-1:0] lo
);

    localparam int CW = $clog2(ITER) + 1;

    mdu_op_e            op_e;
    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [MDU_W-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
    logic [2*MDU_W-1:0] acc_q, acc_d;      // product, or {remainder, quotient}
    logic               is_div_q, is_div_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic               dz_q, dz_d;
    logic [MDU_W-1:0]   dz_hi_q, dz_hi_d;  // raw dividend returned on divide-by-zero
    logic [MDU_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;

    logic               is_signed;
    logic [2*MDU_W-1:0] mag;
    logic [2*MDU_W-1:0] fixed;
    logic [MDU_W:0]     mul_sum;
    logic [2*MDU_W-1:0] mul_next;
    logic [MDU_W:0]     rem_sh;
    logic [MDU_W+1:0]   trial;
    logic [2*MDU_W-1:0] div_next;

    assign op_e      = mdu_op_e'(op);
    assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);

    // Operand magnitudes at issue: {|din1|, |din2|}
    mdu_sign_fix u_issue_abs (
        .din    ({din1, din2}),
        .wide   (1'b0),
        .neg_hi (is_signed & din1[MDU_W-1]),
        .neg_lo (is_signed & din2[MDU_W-1]),
        .dout   (mag)
    );

    // Sign restoration of the finished result
    mdu_sign_fix u_result_fix (
        .din    (acc_q),
        .wide   (~is_div_q),
        .neg_hi (neg_hi_q),
        .neg_lo (neg_lo_q),
        .dout   (fixed)
    );

    // One shift-add step and one restoring-divide step
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*MDU_W-1:MDU_W]} + (acc_q[0] ? {1'b0, a_q} : {(MDU_W+1){1'b0}});
        mul_next = {mul_sum, acc_q[MDU_W-1:1]};
        rem_sh   = {acc_q[2*MDU_W-1:MDU_W], acc_q[MDU_W-1]};
        trial    = {1'b0, rem_sh} - {2'b00, a_q};
        if (!trial[MDU_W+1])
            div_next = {trial[MDU_W-1:0], acc_q[MDU_W-2:0], 1'b1};
        else
            div_next = {rem_sh[MDU_W-1:0], acc_q[MDU_W-2:0], 1'b0};
    end

    // Next-state, issue capture and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        dz_d     = dz_q;
        dz_hi_d  = dz_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op_e)
                        OP_MTHI: hi_d = din1;
                        OP_MTLO: lo_d = din1;
                        OP_MULT, OP_MULTU: begin
                            state_d  = ST_CALC;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            is_div_d = 1'b0;
                            a_d      = mag[2*MDU_W-1:MDU_W];
                            acc_d    = {{MDU_W{1'b0}}, mag[MDU_W-1:0]};
                            neg_hi_d = 1'b0;
                            neg_lo_d = is_signed & (din1[MDU_W-1] ^ din2[MDU_W-1]);
                            dz_d     = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = ST_CALC;
                            busy_d   = 1'b1;
                            cnt_d    = '0;
                            is_div_d = 1'b1;
                            a_d      = mag[MDU_W-1:0];
                            acc_d    = {{MDU_W{1'b0}}, mag[2*MDU_W-1:MDU_W]};
                            neg_hi_d = is_signed & din1[MDU_W-1];
                            neg_lo_d = is_signed & (din1[MDU_W-1] ^ din2[MDU_W-1]);
                            dz_d     = (din2 == '0);
                            dz_hi_d  = din1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (!flush) begin
                    if (dz_q) begin
                        hi_d = dz_hi_q;
                        lo_d = '1;
                    end else begin
                        hi_d = fixed[2*MDU_W-1:MDU_W];
                        lo_d = fixed[MDU_W-1:0];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dz_q     <= 1'b0;
            dz_hi_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            dz_q     <= dz_d;
            dz_hi_q  <= dz_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus random ops scored
// through an expected-result queue, and hand sequences for mt*, flush, reset.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] din1 = '0;
    logic [31:0] din2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    mul_div_unit #(.ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .din1  (din1),
        .din2  (din2),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Issue while busy is a hazard-logic bug; the bench never does it.
    always @(posedge clk) begin
        if (!rst) assert (!(start && busy)) else $error("hazard: start while busy");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Independent reference: 64-bit host arithmetic, MIPS divide-by-zero rule
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = '0;
        e.lo = '0;
        case (o)
            3'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd2: begin up = {32'd0, a} * {32'd0, b}; e.hi = up[63:32]; e.lo = up[31:0]; end
            3'd3, 3'd4: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (o == 3'd3) begin
                    q = sa / sb; r = sa % sb; e.hi = r[31:0]; e.lo = q[31:0];
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; din1 = a; din2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
    endtask

    // Issue, wait for completion with a bound, score against the queue head
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        issue(o, a, b);
        check({name, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, n, 32'd33);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, " hi"}, hi, e.hi);
            check({name, " lo"}, lo, e.lo);
        end
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        exp_t e;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd4, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
        vecs.push_back('{3'd4, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        foreach (vecs[i]) begin
            v = vecs[i];
            e.hi = v.hi; e.lo = v.lo;
            sb_q.push_back(e);
            run_op($sformatf("vec%0d", i), v.op, v.a, v.b);
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            sb_q.push_back(model(ro, ra, rb));
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        // mthi then mtlo on consecutive cycles: no stall, visible next cycle
        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi_kept", hi, 32'h1234_5678);
        check("mtlo busy", {31'd0, busy}, 32'd0);

        // Flush mid-divide leaves HI/LO untouched; reissue completes
        issue(3'd5, 32'hAAAA_0000, 32'd0);
        issue(3'd6, 32'h0000_5555, 32'd0);
        issue(3'd4, 32'd100, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush hi", hi, 32'hAAAA_0000);
        check("flush lo", lo, 32'h0000_5555);
        sb_q.push_back(model(3'd4, 32'd100, 32'd3));
        run_op("reissue", 3'd4, 32'd100, 32'd3);

        // Async reset mid-multiply clears everything before the next edge
        issue(3'd1, 32'd3, 32'd5);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start with flush in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; op = 3'd5; din1 = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_idle mthi", hi, 32'd0);
        op = 3'd1; din1 = 32'd3; din2 = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0; op = 3'd0;
        check("flush_idle mult busy", {31'd0, busy}, 32'd0);

        check("scoreboard drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
